// File: rtl/host_mem_bridge.sv
// host_mem_bridge
//
// Byte-serial bridge that lets an external host read and write the data RAM
// through its secondary port while the CPU keeps running.
//
// Host protocol:
//   - command byte: bit7 = 1 for write, 0 for read; bits[6:0] = words - 1
//   - ADDR_BYTES address bytes, LSB first (bits above ADDR_W are ignored)
//   - write: DATA_BYTES bytes per word, LSB first, repeated for each word
//   - read:  DATA_BYTES bytes per word come back on the out stream, LSB first
//   - consecutive words use auto-incremented addresses, wrapping at 2^ADDR_W
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_data/in_ready        host -> bridge byte stream
//   out_valid/out_data/out_ready     bridge -> host byte stream
//   mem_addr/mem_wdata/mem_we/mem_re RAM port-B request (single-cycle strobes)
//   mem_rdata                        RAM port-B read data, valid MEM_LAT cycles after mem_re
//   busy                             high whenever a command is in progress
//   err                              one-cycle pulse when a command is rejected

`timescale 1ns/1ps

module host_mem_bridge #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int AB_W       = ADDR_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_RREQ,
        S_RWAIT,
        S_RSEND
    } state_t;

    state_t            state_q, state_d;
    logic [AB_W-1:0]   abuf_q, abuf_d;     // address, byte-aligned container
    logic [DATA_W-1:0] wbuf_q, wbuf_d;     // word buffer for both directions
    logic [7:0]        cnt_q, cnt_d;       // byte index within address/word
    logic [7:0]        remain_q, remain_d; // words still to transfer
    logic [7:0]        lat_q, lat_d;       // read latency counter
    logic              wr_q, wr_d;         // current command is a write
    logic              err_q, err_d;

    logic in_fire;
    logic out_fire;

    assign in_ready  = !rst && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA);
    assign out_valid = (state_q == S_RSEND);
    // Read data is shifted out of the low byte, so it stays stable while stalled.
    assign out_data  = (state_q == S_RSEND) ? wbuf_q[7:0] : 8'h00;
    assign mem_addr  = abuf_q[ADDR_W-1:0];
    assign mem_wdata = wbuf_q;
    assign mem_we    = (state_q == S_WRITE);
    assign mem_re    = (state_q == S_RREQ);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        abuf_d   = abuf_q;
        wbuf_d   = wbuf_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        lat_d    = lat_q;
        wr_d     = wr_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    // len = cmd+1 exceeds MAX_BURST exactly when cmd >= MAX_BURST
                    if ({1'b0, in_data[6:0]} >= 8'(MAX_BURST)) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d     = in_data[7];
                        remain_d = {1'b0, in_data[6:0]} + 8'd1;
                        cnt_d    = 8'd0;
                        state_d  = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                if (in_fire) begin
                    // LSB-first bytes enter at the top and shift down
                    abuf_d = (abuf_q >> 8) | (AB_W'(in_data) << (AB_W - 8));
                    if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = wr_q ? S_WDATA : S_RREQ;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_WDATA: begin
                if (in_fire) begin
                    wbuf_d = (wbuf_q >> 8) | (DATA_W'(in_data) << (DATA_W - 8));
                    if (cnt_q == 8'(DATA_BYTES - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_WRITE: begin
                abuf_d[ADDR_W-1:0] = abuf_q[ADDR_W-1:0] + ADDR_W'(1);
                remain_d           = remain_q - 8'd1;
                state_d            = (remain_q == 8'd1) ? S_IDLE : S_WDATA;
            end

            S_RREQ: begin
                lat_d   = 8'd1;
                state_d = S_RWAIT;
            end

            S_RWAIT: begin
                if (lat_q == 8'(MEM_LAT)) begin
                    wbuf_d  = mem_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_RSEND;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end

            S_RSEND: begin
                if (out_fire) begin
                    wbuf_d = wbuf_q >> 8;
                    if (cnt_q == 8'(DATA_BYTES - 1)) begin
                        cnt_d              = 8'd0;
                        abuf_d[ADDR_W-1:0] = abuf_q[ADDR_W-1:0] + ADDR_W'(1);
                        remain_d           = remain_q - 8'd1;
                        state_d            = (remain_q == 8'd1) ? S_IDLE : S_RREQ;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            abuf_q   <= '0;
            wbuf_q   <= '0;
            cnt_q    <= 8'd0;
            remain_q <= 8'd0;
            lat_q    <= 8'd0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            abuf_q   <= abuf_d;
            wbuf_q   <= wbuf_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            lat_q    <= lat_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_host_mem_bridge.sv
// tb_host_mem_bridge
//
// Directed bench for host_mem_bridge with a scoreboard: the stimulus process
// queues expected RAM writes, RAM reads, output bytes and error pulses; a
// monitor on the falling edge pops and compares whenever the DUT shows one.
// A behavioural RAM with one cycle of read latency sits on the memory port.

`timescale 1ns/1ps

module tb_host_mem_bridge;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              err;

    host_mem_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_LAT(1),
        .MAX_BURST(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, registered read (MEM_LAT = 1)
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Scoreboard
    logic [ADDR_W-1:0] exp_wa[$];
    logic [DATA_W-1:0] exp_wd[$];
    logic [ADDR_W-1:0] exp_ra[$];
    logic [7:0]        exp_ob[$];
    int                err_exp   = 0;
    int                out_total = 0;
    int                checks    = 0;
    int                errors    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
            chk("re_during_out_valid", 32'(mem_re & out_valid), 32'd0);
            if (mem_we) begin
                if (exp_wa.size() == 0) begin
                    chk("unexpected_we_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [ADDR_W-1:0] ea;
                    logic [DATA_W-1:0] ed;
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    $display("mem write addr=%05h data=%08h (expect %05h %08h)", mem_addr, mem_wdata, ea, ed);
                    chk("we_addr", 32'(mem_addr), 32'(ea));
                    chk("we_data", mem_wdata, ed);
                end
            end
            if (mem_re) begin
                if (exp_ra.size() == 0) begin
                    chk("unexpected_re_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [ADDR_W-1:0] ra;
                    ra = exp_ra.pop_front();
                    $display("mem read  addr=%05h (expect %05h)", mem_addr, ra);
                    chk("re_addr", 32'(mem_addr), 32'(ra));
                end
            end
            if (out_valid && out_ready) begin
                out_total++;
                if (exp_ob.size() == 0) begin
                    chk("unexpected_out_byte", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] ob;
                    ob = exp_ob.pop_front();
                    $display("out byte  %02h (expect %02h)", out_data, ob);
                    chk("out_byte", 32'(out_data), 32'(ob));
                end
            end
            if (err) begin
                $display("err pulse (expected count %0d)", err_exp);
                chk("err_expected", 32'(err_exp > 0), 32'd1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        rdy      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [23:0] addr);
        send_byte(cmd);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(addr[23:16]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 400 && (busy || exp_wa.size() != 0 || exp_ra.size() != 0 || exp_ob.size() != 0)) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        ram[20'h00010] = 32'h03020100;
        ram[20'h00011] = 32'h07060504;
        ram[20'h00012] = 32'h0B0A0908;
        ram[20'h00013] = 32'h0F0E0D0C;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single write
        push_wr(20'h01234, 32'hDEADBEEF);
        send_cmd(8'h80, 24'h001234);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("wr_we_after_last", 32'(mem_we), 32'd1);
        chk("wr_in_ready_low", 32'(in_ready), 32'd0);
        chk("wr_addr_direct", 32'(mem_addr), 32'h01234);
        @(posedge clk);
        #1;
        chk("wr_busy_falls", 32'(busy), 32'd0);

        // Single read with a three-cycle stall on byte 2
        exp_ra.push_back(20'h01234);
        exp_ob.push_back(8'hEF);
        exp_ob.push_back(8'hBE);
        exp_ob.push_back(8'hAD);
        exp_ob.push_back(8'hDE);
        begin
            int base;
            base = out_total;
            send_cmd(8'h00, 24'h001234);
            chk("rd_re_after_addr", 32'(mem_re), 32'd1);
            @(posedge clk);
            #1;
            chk("rd_wait_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            chk("rd_first_valid", 32'(out_valid), 32'd1);
            chk("rd_first_byte", 32'(out_data), 32'hEF);
            for (int i = 0; i < 50 && out_total < base + 2; i++) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'hAD);
                @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
        end
        wait_idle();

        // Burst write of three words wrapping the address
        push_wr(20'hFFFFF, 32'h11111111);
        push_wr(20'h00000, 32'h22222222);
        push_wr(20'h00001, 32'h33333333);
        send_cmd(8'h82, 24'h0FFFFF);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        wait_idle();

        // Burst read of four words from 0x00010
        for (int i = 0; i < 4; i++) exp_ra.push_back(20'h00010 + 20'(i));
        for (int i = 0; i < 16; i++) exp_ob.push_back(8'(i));
        send_cmd(8'h03, 24'h000010);
        wait_idle();

        // Rejected length, then a normal command right after
        err_exp++;
        send_byte(8'h10);
        chk("bad_len_err", 32'(err), 32'd1);
        chk("bad_len_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("bad_len_err_pulse", 32'(err), 32'd0);
        push_wr(20'h00020, 32'hCAFEF00D);
        send_cmd(8'h80, 24'h000020);
        send_word(32'hCAFEF00D);
        wait_idle();

        // Reset in the middle of a write
        send_cmd(8'h80, 24'h000005);
        send_byte(8'h44);
        send_byte(8'h33);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_in_ready2", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        push_wr(20'h00005, 32'h11223344);
        send_cmd(8'h80, 24'h000005);
        send_word(32'h11223344);
        wait_idle();

        repeat (4) @(posedge clk);
        chk("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_ra.size()), 32'd0);
        chk("out_queue_empty", 32'(exp_ob.size()), 32'd0);
        chk("err_all_seen", 32'(err_exp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
